execute: RTL and testbench
==========================

EXECUTE -- requirements
Module: execute

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the datapath width in bits.
REQ-002 SHALL have parameter REG_BITS, default 5, meaning the register index width.
REQ-003 SHALL have port clock  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning synchronous, active-high reset.
REQ-005 SHALL have these upstream ports:
- in_valid  input  1  meaning the upstream stage holds a valid instruction.
- in_hold  output  1  meaning the upstream stage must keep its outputs this cycle.
- in_pc  input  WIDTH  meaning the instruction address.
- in_operation  input  4  meaning the opcode (REQ-011).
- in_destination  input  REG_BITS  meaning the destination register index.
- in_left, in_right  input  WIDTH  meaning the operand values.
- in_is_writing_memory  input  1  meaning a store instruction.
- in_has_flushed  input  1  meaning the flush marker.
REQ-006 SHALL have these downstream ports:
- out_hold  input  1  meaning the downstream stage cannot accept this cycle.
- out_valid  output  1  meaning the output registers hold a valid result.
- out_pc  output  WIDTH  meaning the registered in_pc.
- out_destination  output  REG_BITS  meaning the registered in_destination.
- out_result  output  WIDTH  meaning the operation result.
- out_store_value  output  WIDTH  meaning the registered in_right.
- out_is_writing_memory  output  1  meaning the registered in_is_writing_memory.
- out_has_flushed  output  1  meaning the registered in_has_flushed.

Function
REQ-007 Output registers SHALL load only on edges where out_hold=0; otherwise they SHALL keep their values.
REQ-008 Single-cycle ops SHALL reach the outputs in 1 cycle: out_valid <= in_valid, and the result is registered on the next non-held edge.
REQ-009 For single-cycle ops, in_hold SHALL equal out_hold && in_valid.
REQ-010 Arithmetic SHALL be modulo 2^WIDTH; carries are discarded; shift amount = in_right[4:0].
REQ-011 Opcodes SHALL be:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
- 5 SHL, 6 SHR (logical), 7 SAR (arithmetic).
- 8 SLT: signed less-than, result 1/0.
- 9 SLTU: unsigned less-than, result 1/0.
- 10 MUL: low WIDTH bits of the product.
- 11 DIVU: unsigned quotient.
- 12 REMU: unsigned remainder.
- 13 PASS: result = in_right.
- 14-15: result 0.
REQ-012 MUL, DIVU and REMU SHALL use a multi-cycle FSM with states IDLE, BUSY and DONE, plus a 5-bit iteration counter.
REQ-013 IDLE -> BUSY SHALL occur when in_valid=1 and the opcode is 10-12: operands latched, counter=0, in_hold=1, and out_valid <= 0 if out_hold=0 (bubble).
REQ-014 BUSY SHALL perform one shift-add or restoring-divide step per cycle, increment the counter, and hold in_hold=1 regardless of out_hold.
REQ-015 BUSY -> DONE SHALL occur after the step with counter=31 (32 steps).
REQ-016 In DONE, in_hold SHALL equal out_hold; on the first edge with out_hold=0 the result is registered with out_valid=1, and the FSM goes to IDLE.
REQ-017 Latency SHALL be: a multi-cycle op presented at edge N with out_hold=0 throughout gives out_valid=1 after edge N+33.
REQ-018 Divide by zero SHALL give DIVU = all ones and REMU = in_left; it takes the same 33-cycle latency and raises no exception.
REQ-019 If in_valid falls in BUSY or DONE (upstream flush), the FSM SHALL return to IDLE next edge, discard the result and register no output.
REQ-020 A multi-cycle op immediately following another SHALL re-enter BUSY from IDLE only; there is no back-to-back overlap.
REQ-021 in_hold SHALL be 0 whenever in_valid=0.

Reset
REQ-022 While reset=1 at an edge:
- out_valid=0, out_has_flushed=0.
- FSM=IDLE, counter=0.
- Other outputs unspecified.
REQ-023 Reset SHALL take priority over out_hold and SHALL abort any BUSY or DONE operation without producing output.

Verification
REQ-024 ADD: in_left=0xFFFFFFFF, in_right=2, in_valid=1 -> after 1 edge, out_result=0x00000001, out_valid=1.
REQ-025 SAR: in_left=0x80000000, in_right=0x24 -> out_result=0xF8000000; SLT with -1 vs 1 -> out_result=1.
REQ-026 DIVU: 100 / 7 -> in_hold=1 for 33 cycles, then out_result=14; REMU gives 2; DIVU by 0 gives 0xFFFFFFFF.
REQ-027 MUL: 0x10000 * 0x10001 with out_hold=1 for 5 cycles in DONE -> outputs unchanged until release, then out_result=0x00010000.
REQ-028 Flush: in_valid dropped at BUSY step 10 -> FSM IDLE next cycle, out_valid stays 0, and a following ADD completes in 1 cycle.
REQ-029 Reset asserted during BUSY -> out_valid=0 and FSM IDLE after 1 edge; in_hold=0 once in_valid=0.

Source files
------------

// File: rtl/execute.sv
// execute: ALU stage with single-cycle ops and a 32-step iterative multiply/divide unit.
module execute #(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_hold,
  input  logic [WIDTH-1:0]    in_pc,
  input  logic [3:0]          in_operation,
  input  logic [REG_BITS-1:0] in_destination,
  input  logic [WIDTH-1:0]    in_left,
  input  logic [WIDTH-1:0]    in_right,
  input  logic                in_is_writing_memory,
  input  logic                in_has_flushed,
  input  logic                out_hold,
  output logic                out_valid,
  output logic [WIDTH-1:0]    out_pc,
  output logic [REG_BITS-1:0] out_destination,
  output logic [WIDTH-1:0]    out_result,
  output logic [WIDTH-1:0]    out_store_value,
  output logic                out_is_writing_memory,
  output logic                out_has_flushed
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [4:0] cnt;
  logic [3:0] op;
  logic [WIDTH-1:0] acc, opa, opb, alu, res;
  logic [WIDTH:0] r;
  logic [4:0] sh;
  logic multi, start, fire, ge;
  assign multi = in_operation >= 4'd10 && in_operation <= 4'd12;
  assign sh = in_right[4:0];
  always_ff @(posedge clock) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = !in_valid ? IDLE :
              state == IDLE ? (multi ? BUSY : IDLE) :
              state == BUSY ? (cnt == 5'd31 ? DONE : BUSY) :
              (out_hold ? DONE : IDLE);
  end
  always_comb begin
    start   = state == IDLE && in_valid && multi;
    fire    = in_valid && (state == IDLE ? !multi : state == DONE);
    in_hold = in_valid && (state == BUSY || start || out_hold);
  end
  always_comb begin
    case (in_operation)
      4'd0:    alu = in_left + in_right;
      4'd1:    alu = in_left - in_right;
      4'd2:    alu = in_left & in_right;
      4'd3:    alu = in_left | in_right;
      4'd4:    alu = in_left ^ in_right;
      4'd5:    alu = in_left << sh;
      4'd6:    alu = in_left >> sh;
      4'd7:    alu = $signed(in_left) >>> sh;
      4'd8:    alu = {{(WIDTH-1){1'b0}}, $signed(in_left) < $signed(in_right)};
      4'd9:    alu = {{(WIDTH-1){1'b0}}, in_left < in_right};
      4'd13:   alu = in_right;
      default: alu = '0;
    endcase
  end
  // restoring divide: acc is the partial remainder, opa shifts dividend out and quotient in
  assign r   = {acc, opa[WIDTH-1]};
  assign ge  = r >= {1'b0, opb};
  assign res = state == DONE ? (op == 4'd11 ? opa : acc) : alu;
  always_ff @(posedge clock) begin
    if (reset) cnt <= '0;
    else cnt <= start ? 5'd0 : state == BUSY ? cnt + 5'd1 : cnt;
    if (start) begin
      acc <= '0;
      opa <= in_left;
      opb <= in_right;
      op  <= in_operation;
    end else if (state == BUSY && op == 4'd10) begin
      acc <= acc + (opb[0] ? opa : '0);
      opa <= opa << 1;
      opb <= opb >> 1;
    end else if (state == BUSY) begin
      acc <= ge ? r[WIDTH-1:0] - opb : r[WIDTH-1:0];
      opa <= {opa[WIDTH-2:0], ge};
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid       <= 1'b0;
      out_has_flushed <= 1'b0;
    end else if (!out_hold) begin
      out_valid <= fire;
      if (fire) begin
        out_pc                <= in_pc;
        out_destination       <= in_destination;
        out_result            <= res;
        out_store_value       <= in_right;
        out_is_writing_memory <= in_is_writing_memory;
        out_has_flushed       <= in_has_flushed;
      end
    end
  end
endmodule

// File: tb/tb_execute.sv
// tb_execute: randomized scoreboard bench for execute against an arithmetic reference model.
module tb_execute;
  logic clock = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_hold, in_is_writing_memory = 1'b0, in_has_flushed = 1'b0;
  logic [31:0] in_pc = '0, in_left = '0, in_right = '0;
  logic [3:0] in_operation = '0;
  logic [4:0] in_destination = '0;
  logic out_hold = 1'b0, out_valid, out_is_writing_memory, out_has_flushed;
  logic [31:0] out_pc, out_result, out_store_value;
  logic [4:0] out_destination;

  execute dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_hold(in_hold), .in_pc(in_pc),
    .in_operation(in_operation), .in_destination(in_destination), .in_left(in_left),
    .in_right(in_right), .in_is_writing_memory(in_is_writing_memory),
    .in_has_flushed(in_has_flushed), .out_hold(out_hold), .out_valid(out_valid),
    .out_pc(out_pc), .out_destination(out_destination), .out_result(out_result),
    .out_store_value(out_store_value), .out_is_writing_memory(out_is_writing_memory),
    .out_has_flushed(out_has_flushed)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [31:0] st;
    logic        wm;
    logic        hf;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0, n_fail = 0, last_cyc = 0;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    int unsigned s;
    logic [63:0] p;
    s = b[4:0];
    p = 64'(a) * 64'(b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << s;
      4'd6: return a >> s;
      4'd7: return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
      4'd8: return (a[31] != b[31]) ? 32'(a[31]) : 32'(a < b);
      4'd9: return 32'(a < b);
      4'd10: return p[31:0];
      4'd11: return b == 0 ? 32'hFFFF_FFFF : a / b;
      4'd12: return b == 0 ? a : a % b;
      4'd13: return b;
      default: return 32'h0;
    endcase
  endfunction

  // mode: 0 = never held downstream, 1 = random downstream hold, 2 = hold 5 cycles once in DONE
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int mode, input int flush_at);
    exp_t e;
    int cyc;
    bit done;
    e.res = model(op, a, b);
    e.pc = $urandom;
    e.dest = 5'($urandom);
    e.st = b;
    e.wm = 1'($urandom);
    e.hf = 1'($urandom);
    cyc = 0;
    done = 0;
    while (!done) begin
      @(negedge clock);
      in_operation = op; in_left = a; in_right = b; in_pc = e.pc;
      in_destination = e.dest; in_is_writing_memory = e.wm; in_has_flushed = e.hf;
      out_hold = mode == 1 ? ($urandom_range(0, 3) == 0) : (mode == 2 && cyc >= 33 && cyc < 38);
      if (flush_at > 0 && cyc == flush_at) begin
        in_valid = 1'b0;
        #1 check("flush_in_hold", 128'(in_hold), 128'(0));
        done = 1;
      end else begin
        in_valid = 1'b1;
        #1;
        if (!in_hold) begin
          sb.push_back(e);
          done = 1;
        end else if (cyc > 300) begin
          check("accept_timeout", 128'(cyc), 128'(0));
          done = 1;
        end
      end
      last_cyc = cyc;
      cyc++;
    end
  endtask

  task automatic idle();
    @(negedge clock);
    in_valid = 1'b0;
    out_hold = 1'($urandom_range(0, 1));
    #1 check("idle_in_hold", 128'(in_hold), 128'(0));
  endtask

  logic [102:0] act;
  logic [103:0] snap = '0;
  assign act = {out_result, out_pc, out_destination, out_store_value, out_is_writing_memory, out_has_flushed};

  always @(posedge clock) begin
    logic hp, rp;
    exp_t e;
    hp = out_hold;
    rp = reset;
    #1;
    if (!rp && hp) check("held_outputs", 128'({out_valid, act}), 128'(snap));
    else if (!rp && out_valid) begin
      if (sb.size() == 0) check("unexpected_output", 128'(act), 128'(0));
      else begin
        e = sb.pop_front();
        check("result", 128'(act), 128'(e));
      end
    end
    snap = {out_valid, act};
  end

  initial begin
    int op, a, b, mode;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_out_has_flushed", 128'(out_has_flushed), 128'(0));
    issue(4'd0, 32'hFFFF_FFFF, 32'd2, 0, 0);
    check("add_latency", 128'(last_cyc), 128'(0));
    @(posedge clock) #2;
    check("add_direct", 128'({out_valid, out_result}), 128'({1'b1, 32'h1}));
    issue(4'd7, 32'h8000_0000, 32'h24, 0, 0);
    @(posedge clock) #2 check("sar_direct", 128'(out_result), 128'(32'hF800_0000));
    issue(4'd8, 32'hFFFF_FFFF, 32'd1, 0, 0);
    @(posedge clock) #2 check("slt_direct", 128'(out_result), 128'(1));
    issue(4'd11, 32'd100, 32'd7, 0, 0);
    check("divu_hold_cycles", 128'(last_cyc), 128'(33));
    @(posedge clock) #2 check("divu_direct", 128'({out_valid, out_result}), 128'({1'b1, 32'd14}));
    issue(4'd12, 32'd100, 32'd7, 0, 0);
    @(posedge clock) #2 check("remu_direct", 128'(out_result), 128'(2));
    issue(4'd11, 32'd55, 32'd0, 0, 0);
    check("div0_hold_cycles", 128'(last_cyc), 128'(33));
    @(posedge clock) #2 check("div0_direct", 128'(out_result), 128'(32'hFFFF_FFFF));
    issue(4'd10, 32'h1_0000, 32'h1_0001, 2, 0);
    check("mul_held_cycles", 128'(last_cyc), 128'(38));
    @(negedge clock) out_hold = 1'b0;
    check("mul_direct", 128'(out_result), 128'(32'h0001_0000));
    issue(4'd11, 32'd1000, 32'd3, 0, 11);
    @(posedge clock) #2 check("flush_no_output", 128'(out_valid), 128'(0));
    issue(4'd0, 32'd5, 32'd6, 0, 0);
    check("add_after_flush_latency", 128'(last_cyc), 128'(0));
    issue(4'd11, 32'd999, 32'd4, 0, 6);
    @(negedge clock);
    in_valid = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    in_valid = 1'b0;
    @(posedge clock) #1;
    check("reset_busy_out_valid", 128'(out_valid), 128'(0));
    check("reset_busy_in_hold", 128'(in_hold), 128'(0));
    @(negedge clock) reset = 1'b0;
    issue(4'd1, 32'd3, 32'd10, 0, 0);
    check("add_after_reset_latency", 128'(last_cyc), 128'(0));
    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 15);
      a = $urandom_range(0, 3) == 0 ? $urandom_range(0, 40) : $urandom;
      b = $urandom_range(0, 3) == 0 ? $urandom_range(0, 9) : $urandom;
      mode = $urandom_range(0, 1);
      if ($urandom_range(0, 4) == 0) idle();
      issue(4'(op), 32'(a), 32'(b), mode, $urandom_range(0, 7) == 0 ? $urandom_range(1, 36) : 0);
    end
    idle();
    @(negedge clock) out_hold = 1'b0;
    in_valid = 1'b0;
    repeat (4) @(negedge clock);
    check("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
